// File: rtl/dmem_bus_if.sv
// Data-memory bus bridge: one word-wide bus request per MEM-stage load/store, with lane steering and load alignment.
// Optional misalignment trap enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_bus_if #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] ALU_Result_M,
  input  logic [31:0] WriteData_M,
  output logic [31:0] ReadData_M,
  output logic        Stall_M,
  output logic        Misalign_M,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        rd_q;
  logic [31:0] rdata_q;

  logic        access;
  logic        misalign;
  logic        start;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;

  assign access = MemRead_M | MemWrite_M;

`ifdef DMEM_MISALIGN_CHECK_EN
  logic is_half;
  logic is_word;

  always_comb begin
    is_half  = (funct3_M == 3'b001) || (!MemWrite_M && funct3_M == 3'b101);
    is_word  = (funct3_M == 3'b010);
    misalign = access && ((is_half && ALU_Result_M[0]) || (is_word && |ALU_Result_M[1:0]));
  end

  assign Misalign_M = rst_n && (state == IDLE) && misalign;
  // A trapped load must present zero in the same cycle the pipeline moves on.
  assign ReadData_M = (Misalign_M && !MemWrite_M) ? 32'h0 : rdata_q;
`else
  assign misalign   = 1'b0;
  assign Misalign_M = 1'b0;
  assign ReadData_M = rdata_q;
`endif

  // rst_n gating keeps Stall_M low while reset is held, even with a live access in MEM.
  assign start   = rst_n && (state == IDLE) && access && !misalign;
  assign Stall_M = start || (state == BUSY);

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = 32'h0;
    if (MemWrite_M) begin
      case (funct3_M)
        3'b000: begin
          be_n    = 4'b0001 << ALU_Result_M[1:0];
          wdata_n = {4{WriteData_M[7:0]}};
        end
        3'b001: begin
          be_n    = ALU_Result_M[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{WriteData_M[15:0]}};
        end
        default: wdata_n = WriteData_M;
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_data = {24'h0, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ld_data = {16'h0, half_sel};
      default: ld_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_err   <= 1'b0;
      rdata_q   <= 32'h0;
      f3_q      <= 3'h0;
      off_q     <= 2'h0;
      rd_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus_err <= 1'b0;
          cnt     <= 8'h0;
          if (start) begin
            state     <= BUSY;
            bus_req   <= 1'b1;
            bus_we    <= MemWrite_M;
            bus_be    <= be_n;
            bus_addr  <= {ALU_Result_M[31:2], 2'b00};
            bus_wdata <= wdata_n;
            f3_q      <= funct3_M;
            off_q     <= ALU_Result_M[1:0];
            rd_q      <= !MemWrite_M;
          end
        end
        BUSY: begin
          if (bus_ready) begin
            bus_req <= 1'b0;
            state   <= DONE;
            if (rd_q) rdata_q <= ld_data;
          end else if (cnt == CNT_LAST) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
            if (rd_q) rdata_q <= 32'h0;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        DONE: begin
          bus_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed bench for dmem_bus_if: scoreboard of expected bus fields and load results per access.
module tb_dmem_bus_if;

  logic        clk;
  logic        rst_n;
  logic        MemRead_M;
  logic        MemWrite_M;
  logic [2:0]  funct3_M;
  logic [31:0] ALU_Result_M;
  logic [31:0] WriteData_M;
  logic [31:0] ReadData_M;
  logic        Stall_M;
  logic        Misalign_M;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        err;
    int          stalls;
    int          busy;
  } exp_t;

  exp_t sbq[$];

  dmem_bus_if #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MemRead_M    (MemRead_M),
    .MemWrite_M   (MemWrite_M),
    .funct3_M     (funct3_M),
    .ALU_Result_M (ALU_Result_M),
    .WriteData_M  (WriteData_M),
    .ReadData_M   (ReadData_M),
    .Stall_M      (Stall_M),
    .Misalign_M   (Misalign_M),
    .bus_err      (bus_err),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_ready    (bus_ready),
    .bus_rdata    (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int waits,
                            input logic [31:0] e_addr, input logic [3:0] e_be,
                            input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                            input logic e_err, input int e_stalls, input int e_busy);
    exp_t e;
    int   stalls;
    int   busy;
    bit   done;
    e = '{addr: e_addr, be: e_be, wdata: e_wdata, we: wr, rdata: e_rdata,
          err: e_err, stalls: e_stalls, busy: e_busy};
    @(posedge clk); #1;
    MemRead_M    = rd;
    MemWrite_M   = wr;
    funct3_M     = f3;
    ALU_Result_M = a;
    WriteData_M  = wd;
    sbq.push_back(e);
    stalls = 0;
    busy   = 0;
    done   = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c == 0) check("misalign_low", {31'h0, Misalign_M}, 32'h0);
      if (!Stall_M) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (bus_req) begin
        busy++;
        check("bus_addr", bus_addr, sbq[0].addr);
        check("bus_be", {28'h0, bus_be}, {28'h0, sbq[0].be});
        check("bus_we", {31'h0, bus_we}, {31'h0, sbq[0].we});
        check("bus_wdata", bus_wdata, sbq[0].wdata);
        if (busy == waits + 1) begin
          bus_ready = 1'b1;
          bus_rdata = rdat;
        end
      end
      @(posedge clk); #1;
      bus_ready = 1'b0;
      bus_rdata = 32'hA5A5_5A5A;
    end
    check("access_completed", {31'h0, done}, 32'h1);
    e = sbq.pop_front();
    check("ReadData_M", ReadData_M, e.rdata);
    check("bus_err_done", {31'h0, bus_err}, {31'h0, e.err});
    check("bus_req_done", {31'h0, bus_req}, 32'h0);
    check("stall_cycles", 32'(stalls), 32'(e.stalls));
    check("busy_cycles", 32'(busy), 32'(e.busy));
    @(posedge clk); #1;
    MemRead_M  = 1'b0;
    MemWrite_M = 1'b0;
    @(negedge clk);
    check("bus_err_pulse_end", {31'h0, bus_err}, 32'h0);
    check("bus_req_gap", {31'h0, bus_req}, 32'h0);
  endtask

  initial begin
    rst_n        = 1'b0;
    MemRead_M    = 1'b0;
    MemWrite_M   = 1'b0;
    funct3_M     = 3'b000;
    ALU_Result_M = 32'h0;
    WriteData_M  = 32'h0;
    bus_ready    = 1'b0;
    bus_rdata    = 32'h0;

    #12;
    check("rst_bus_req", {31'h0, bus_req}, 32'h0);
    check("rst_bus_we", {31'h0, bus_we}, 32'h0);
    check("rst_bus_be", {28'h0, bus_be}, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_ReadData", ReadData_M, 32'h0);
    check("rst_bus_err", {31'h0, bus_err}, 32'h0);
    check("rst_Stall", {31'h0, Stall_M}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // LW, zero wait
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
               32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 2, 1);
    // LB / LBU at lane 3
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0,
               32'h100, 4'b1111, 32'h0, 32'hFFFFFF80, 0, 2, 1);
    run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0,
               32'h100, 4'b1111, 32'h0, 32'h00000080, 0, 2, 1);
    // SH upper half, 4 wait cycles; load result holds
    run_access(0, 1, 3'b001, 32'h0A2, 32'h1234ABCD, 32'h0, 4,
               32'h0A0, 4'b1100, 32'hABCDABCD, 32'h00000080, 0, 6, 5);
    // SB lane 1, 1 wait
    run_access(0, 1, 3'b000, 32'h001, 32'h000000EE, 32'h0, 1,
               32'h000, 4'b0010, 32'hEEEEEEEE, 32'h00000080, 0, 3, 2);
    // LH upper (sign), LHU lower (zero)
    run_access(1, 0, 3'b001, 32'h002, 32'h0, 32'h8001_1234, 0,
               32'h000, 4'b1111, 32'h0, 32'hFFFF8001, 0, 2, 1);
    run_access(1, 0, 3'b101, 32'h000, 32'h0, 32'h8001_1234, 2,
               32'h000, 4'b1111, 32'h0, 32'h00001234, 0, 4, 3);
    // SW, with read also set: handled as write
    run_access(1, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 0,
               32'h204, 4'b1111, 32'hCAFEF00D, 32'h00001234, 0, 2, 1);
    // Undefined load code returns the raw word
    run_access(1, 0, 3'b011, 32'h008, 32'h0, 32'h5566_7788, 0,
               32'h008, 4'b1111, 32'h0, 32'h55667788, 0, 2, 1);
    // Timeout: ready never comes
    run_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 1000,
               32'h300, 4'b1111, 32'h0, 32'h0, 1, 9, 8);

`ifdef DMEM_MISALIGN_CHECK_EN
    @(posedge clk); #1;
    MemRead_M    = 1'b1;
    funct3_M     = 3'b010;
    ALU_Result_M = 32'h102;
    @(negedge clk);
    check("mis_flag", {31'h0, Misalign_M}, 32'h1);
    check("mis_stall", {31'h0, Stall_M}, 32'h0);
    check("mis_ReadData", ReadData_M, 32'h0);
    @(posedge clk); #1;
    MemRead_M = 1'b0;
    @(negedge clk);
    check("mis_no_req", {31'h0, bus_req}, 32'h0);
`else
    run_access(1, 0, 3'b010, 32'h102, 32'h0, 32'h1122_3344, 0,
               32'h100, 4'b1111, 32'h0, 32'h11223344, 0, 2, 1);
`endif

    // bus_ready outside BUSY must not start anything
    @(posedge clk); #1;
    bus_ready = 1'b1;
    @(negedge clk);
    check("idle_ready_stall", {31'h0, Stall_M}, 32'h0);
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(negedge clk);
    check("idle_ready_req", {31'h0, bus_req}, 32'h0);
    check("idle_ready_err", {31'h0, bus_err}, 32'h0);
    run_access(1, 0, 3'b010, 32'h040, 32'h0, 32'h0BAD_F00D, 0,
               32'h040, 4'b1111, 32'h0, 32'h0BADF00D, 0, 2, 1);

    // Reset in the middle of BUSY
    @(posedge clk); #1;
    MemRead_M    = 1'b1;
    funct3_M     = 3'b010;
    ALU_Result_M = 32'h400;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_req", {31'h0, bus_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'h0, bus_req}, 32'h0);
    check("async_rst_stall", {31'h0, Stall_M}, 32'h0);
    MemRead_M = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req", {31'h0, bus_req}, 32'h0);
    check("post_rst_stall", {31'h0, Stall_M}, 32'h0);
    run_access(1, 0, 3'b010, 32'h404, 32'h0, 32'h7777_0001, 0,
               32'h404, 4'b1111, 32'h0, 32'h77770001, 0, 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
